// File: rtl/gshare_btb_predictor_pkg.sv
// Shared constants for the gshare/bimodal next-PC predictor.
// Counter encodings and index-mode selectors.
package gshare_btb_predictor_pkg;

  localparam int PRED_MODE_BIMODAL = 0;
  localparam int PRED_MODE_GSHARE  = 1;

  localparam logic [1:0] CTR_STRONG_NT = 2'd0;
  localparam logic [1:0] CTR_WEAK_NT   = 2'd1;
  localparam logic [1:0] CTR_WEAK_T    = 2'd2;
  localparam logic [1:0] CTR_STRONG_T  = 2'd3;

  localparam logic [1:0] PRED_ALLOC_CTR = CTR_WEAK_T;

endpackage

// File: rtl/gshare_btb_predictor_sat_counter2.sv
// 2-bit saturating direction counter, next-state only.
// Pure combinational; the caller owns the storage.
module sat_counter2
  import gshare_btb_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (1'b1)
      taken && (ctr != CTR_STRONG_T):   ctr_next = ctr + 2'd1;
      !taken && (ctr != CTR_STRONG_NT): ctr_next = ctr - 2'd1;
      default:                          ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Tagged direct-mapped BTB with 2-bit direction counters.
// Bimodal or gshare indexing; combinational lookup, EX-stage training.
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         PC_W     = 16,
  parameter int         GHR_W    = 6,
  parameter int         MODE     = PRED_MODE_GSHARE,
  parameter logic [1:0] CTR_INIT = CTR_WEAK_NT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_if,
  output logic [31:0]     npc_pred,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [31:0]     upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_cond,
  output logic [31:0]     hit_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic             cond_q  [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [GHR_W-1:0] ghr_q;

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [PC_W-1:0]  pc,
    input logic [GHR_W-1:0] h
  );
    logic [IDX_W-1:0] base;
    base = pc[IDX_W+1:2];
    if (MODE == PRED_MODE_GSHARE)
      base[GHR_W-1:0] = base[GHR_W-1:0] ^ h;
    return base;
  endfunction

  logic [IDX_W-1:0] l_idx, u_idx;
  logic             hit, u_hit;
  logic [1:0]       ctr_nx;
  logic             unused_bits;

  assign unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

  assign l_idx = idx_of(pc_if, ghr_q);
  assign u_idx = idx_of(upd_pc, ghr_q);

  // Gated by rst so outputs are defined before the arrays clear.
  assign hit = !rst && valid_q[l_idx]
             && (tag_q[l_idx] == pc_if[PC_W-1:IDX_W+2]);
  assign u_hit = valid_q[u_idx]
               && (tag_q[u_idx] == upd_pc[PC_W-1:IDX_W+2]);

  assign pred_taken = hit && (!cond_q[l_idx] || ctr_q[l_idx][1]);
  assign npc_pred = pred_taken ? tgt_q[l_idx]
                               : 32'(pc_if) + 32'd4;

  sat_counter2 u_ctr (
    .ctr      (ctr_q[u_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      ghr_q     <= '0;
      hit_count <= '0;
    end else begin
      if (upd_valid) begin
        if (u_hit) begin
          ctr_q[u_idx]  <= ctr_nx;
          cond_q[u_idx] <= upd_is_cond;
          if (upd_taken)
            tgt_q[u_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= upd_pc[PC_W-1:IDX_W+2];
          tgt_q[u_idx]   <= upd_target;
          cond_q[u_idx]  <= upd_is_cond;
          ctr_q[u_idx]   <= PRED_ALLOC_CTR;
        end
        if (upd_is_cond)
          ghr_q <= (ghr_q << 1) | GHR_W'(upd_taken);
      end
      if (hit && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: bimodal and gshare instances side by side.
// Directed table, hand sequences, then random traffic against a reference model.
module tb_gshare_btb_predictor;

  logic        clk;
  logic        rst;
  logic [15:0] pc_if;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_cond;
  logic [1:0]  pt;
  logic [31:0] np0, np1, hc0, hc1;

  gshare_btb_predictor #(
    .ENTRIES(64), .PC_W(16), .GHR_W(6), .MODE(0), .CTR_INIT(2'b01)
  ) d0 (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .npc_pred(np0), .pred_taken(pt[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_cond(upd_is_cond), .hit_count(hc0)
  );

  gshare_btb_predictor #(
    .ENTRIES(64), .PC_W(16), .GHR_W(2), .MODE(1), .CTR_INIT(2'b01)
  ) d1 (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .npc_pred(np1), .pred_taken(pt[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_cond(upd_is_cond), .hit_count(hc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endfunction

  // Reference model: one BTB per instance, plain integer arithmetic.
  bit          m_valid [2][64];
  int unsigned m_tag   [2][64];
  int unsigned m_tgt   [2][64];
  bit          m_cond  [2][64];
  int          m_ctr   [2][64];
  int unsigned m_ghr   [2];
  int unsigned m_hits  [2];
  bit          m_hit   [2];
  int          ghr_len [2] = '{6, 2};

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) m_valid[d][i] = 0;
      m_ghr[d] = 0;
      m_hits[d] = 0;
    end
  endfunction

  function automatic int unsigned m_index(int d, int unsigned pc);
    int unsigned i;
    i = (pc / 4) % 64;
    if (d == 1) i = i ^ (m_ghr[d] % (1 << ghr_len[d]));
    return i;
  endfunction

  function automatic void m_lookup(int d, int unsigned pc, bit r,
                                   output bit h, output bit tk,
                                   output int unsigned npc);
    int unsigned i;
    i = m_index(d, pc);
    h = !r && m_valid[d][i] && (m_tag[d][i] == pc / 256);
    tk = h && (!m_cond[d][i] || m_ctr[d][i] >= 2);
    npc = tk ? m_tgt[d][i] : pc + 4;
  endfunction

  function automatic void m_update(int d, int unsigned pc,
                                   int unsigned tgt, bit t, bit c);
    int unsigned i;
    i = m_index(d, pc);
    if (m_valid[d][i] && m_tag[d][i] == pc / 256) begin
      m_ctr[d][i] = t ? ((m_ctr[d][i] == 3) ? 3 : m_ctr[d][i] + 1)
                      : ((m_ctr[d][i] == 0) ? 0 : m_ctr[d][i] - 1);
      if (t) m_tgt[d][i] = tgt;
      m_cond[d][i] = c;
    end else if (t) begin
      m_valid[d][i] = 1;
      m_tag[d][i] = pc / 256;
      m_tgt[d][i] = tgt;
      m_cond[d][i] = c;
      m_ctr[d][i] = 2;
    end
    if (c) m_ghr[d] = ((m_ghr[d] << 1) | t) % (1 << ghr_len[d]);
  endfunction

  bit          cur_r, cur_uv, cur_ut, cur_uc;
  int unsigned cur_pc, cur_upc, cur_utgt;

  task automatic drive(bit r, int unsigned pc, bit uv,
                       int unsigned upc, int unsigned utgt,
                       bit ut, bit uc);
    bit tk;
    int unsigned npc;
    cur_r = r; cur_pc = pc; cur_uv = uv;
    cur_upc = upc; cur_utgt = utgt; cur_ut = ut; cur_uc = uc;
    rst = r;
    pc_if = pc[15:0];
    upd_valid = uv;
    upd_pc = upc[15:0];
    upd_target = utgt;
    upd_taken = ut;
    upd_is_cond = uc;
    #4;
    m_lookup(0, pc, r, m_hit[0], tk, npc);
    chk("m0_taken", 32'(pt[0]), 32'(tk));
    chk("m0_npc", np0, npc);
    chk("m0_hits", hc0, m_hits[0]);
    m_lookup(1, pc, r, m_hit[1], tk, npc);
    chk("m1_taken", 32'(pt[1]), 32'(tk));
    chk("m1_npc", np1, npc);
    chk("m1_hits", hc1, m_hits[1]);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (cur_r) m_reset();
    else
      for (int d = 0; d < 2; d++) begin
        if (m_hit[d]) m_hits[d]++;
        if (cur_uv) m_update(d, cur_upc, cur_utgt, cur_ut, cur_uc);
      end
    #1;
  endtask

  typedef struct {
    bit r; int unsigned pc;
    bit uv; int unsigned upc; int unsigned utgt; bit ut; bit uc;
    bit e_tk; int unsigned e_npc; int unsigned e_hc;
  } vec_t;

  vec_t tbl[23];

  function automatic int unsigned rand_pc();
    case ($urandom % 4)
      0: return 32'h8000 + ($urandom % 16) * 4;
      1: return 32'h8100 + ($urandom % 16) * 4;
      2: return 32'hFFFC;
      default: return $urandom % 65536 & 32'hFFFC;
    endcase
  endfunction

  initial begin
    // bimodal instance expectations, derived by hand
    tbl[0]  = '{1, 'h8000, 0, 0, 0, 0, 0, 0, 'h8004, 0};
    tbl[1]  = '{0, 'h8000, 1, 'h8010, 'h8040, 1, 1, 0, 'h8004, 0};
    tbl[2]  = '{0, 'h8010, 0, 0, 0, 0, 0, 1, 'h8040, 0};
    tbl[3]  = '{0, 'h8010, 1, 'h8010, 'h8040, 0, 1, 1, 'h8040, 1};
    tbl[4]  = '{0, 'h8010, 1, 'h8010, 'h8040, 0, 1, 0, 'h8014, 2};
    tbl[5]  = '{0, 'h8010, 0, 0, 0, 0, 0, 0, 'h8014, 3};
    for (int k = 6; k < 11; k++)
      tbl[k] = '{0, 'h9000, 1, 'h8010, 'h8040, 1, 1, 0, 'h9004, 4};
    tbl[11] = '{0, 'h9000, 1, 'h8010, 'h8040, 0, 1, 0, 'h9004, 4};
    tbl[12] = '{0, 'h8010, 0, 0, 0, 0, 0, 1, 'h8040, 4};
    tbl[13] = '{0, 'h8010, 1, 'h8110, 'h8200, 1, 1, 1, 'h8040, 5};
    tbl[14] = '{0, 'h8010, 0, 0, 0, 0, 0, 0, 'h8014, 6};
    tbl[15] = '{0, 'h8110, 0, 0, 0, 0, 0, 1, 'h8200, 6};
    tbl[16] = '{0, 'hFFFC, 0, 0, 0, 0, 0, 0, 'h10000, 7};
    tbl[17] = '{0, 'h8030, 1, 'h8030, 'h8400, 1, 0, 0, 'h8034, 7};
    tbl[18] = '{0, 'h8030, 1, 'h8030, 'h8400, 0, 0, 1, 'h8400, 7};
    tbl[19] = '{0, 'h8030, 0, 0, 0, 0, 0, 1, 'h8400, 8};
    tbl[20] = '{1, 'h8010, 1, 'h8050, 'h8500, 1, 1, 0, 'h8014, 9};
    tbl[21] = '{0, 'h8050, 0, 0, 0, 0, 0, 0, 'h8054, 0};
    tbl[22] = '{0, 'h8010, 0, 0, 0, 0, 0, 0, 'h8014, 0};

    rst = 1'b1; pc_if = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_target = '0; upd_taken = 1'b0; upd_is_cond = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_reset();

    for (int k = 0; k < 23; k++) begin
      drive(tbl[k].r, tbl[k].pc, tbl[k].uv, tbl[k].upc,
            tbl[k].utgt, tbl[k].ut, tbl[k].uc);
      chk($sformatf("row%0d_taken", k), 32'(pt[0]), 32'(tbl[k].e_tk));
      chk($sformatf("row%0d_npc", k), np0, tbl[k].e_npc);
      chk($sformatf("row%0d_hits", k), hc0, tbl[k].e_hc);
      finish_cycle();
    end

    // gshare: T,N at 0x8020 leaves ghr=2'b10, so 0x8020 maps to 0x0A
    drive(1, 'h8000, 0, 0, 0, 0, 0); finish_cycle();
    drive(0, 'h8000, 1, 'h8020, 'h8100, 1, 1); finish_cycle();
    drive(0, 'h8000, 1, 'h8020, 'h8200, 0, 1); finish_cycle();
    drive(0, 'h8020, 1, 'h8020, 'h8300, 1, 0);
    chk("gs_pre_taken", 32'(pt[1]), 32'd0);
    chk("gs_pre_npc", np1, 32'h8024);
    finish_cycle();
    drive(0, 'h8020, 0, 0, 0, 0, 0);
    chk("gs_0a_taken", 32'(pt[1]), 32'd1);
    chk("gs_0a_npc", np1, 32'h8300);
    finish_cycle();
    drive(0, 'h8028, 0, 0, 0, 0, 0);
    chk("gs_08_taken", 32'(pt[1]), 32'd1);
    chk("gs_08_npc", np1, 32'h8100);
    finish_cycle();

    drive(1, 'h8000, 0, 0, 0, 0, 0); finish_cycle();
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom % 200) == 0, rand_pc(), ($urandom % 4) != 0,
            rand_pc(), $urandom & 32'hFFFF_FFFC,
            $urandom % 2, ($urandom % 3) != 0);
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
